// File: rtl/pic_pkg.sv
// ---------------------------------------------------------------------------
// pic_pkg
// Shared definitions for the 8259-style interrupt sequencer:
//   - level-count / level-index width constants
//   - sequencer FSM state encoding
//   - the level reported for a spurious acknowledge
//   - small helpers for priority rank and one-hot level masks
// ---------------------------------------------------------------------------
package pic_pkg;

    localparam int NLVL  = 8;   // number of interrupt levels
    localparam int LVL_W = 3;   // bits needed to index a level

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        ACK1 = 2'd2
    } pic_state_e;

    // Level returned in the vector when nothing valid remains at the first INTA.
    localparam logic [LVL_W-1:0] SPURIOUS_LVL = 3'd7;

    // Priority rank of a level relative to the rotating base; 0 is the highest.
    // The 3-bit subtraction gives the modulo-8 wrap for free.
    function automatic logic [LVL_W-1:0] lvl_rank(input logic [LVL_W-1:0] lvl,
                                                  input logic [LVL_W-1:0] base);
        return lvl - base;
    endfunction

    function automatic logic [NLVL-1:0] lvl_onehot(input logic [LVL_W-1:0] lvl);
        return NLVL'(1) << lvl;
    endfunction

endpackage

// File: rtl/pic_prio_select.sv
// ---------------------------------------------------------------------------
// pic_prio_select
// Combinational rotating-priority encoder: returns the set bit of req_i with
// the lowest rank relative to base_i.
//   req_i    in  8  request vector
//   base_i   in  3  level currently holding rank 0
//   lvl_o    out 3  winning level (0 when nothing is set)
//   found_o  out 1  at least one bit of req_i is set
// ---------------------------------------------------------------------------
module pic_prio_select
    import pic_pkg::*;
(
    input  logic [NLVL-1:0]  req_i,
    input  logic [LVL_W-1:0] base_i,
    output logic [LVL_W-1:0] lvl_o,
    output logic             found_o
);

    logic [LVL_W-1:0] lvl_l;

    // Walk from the lowest priority (rank 7) up to rank 0 so the last hit,
    // i.e. the lowest rank, is the one that sticks.
    always_comb begin
        lvl_o   = '0;
        found_o = 1'b0;
        lvl_l   = '0;
        for (int i = NLVL - 1; i >= 0; i--) begin
            lvl_l = base_i + LVL_W'(i);
            if (req_i[lvl_l]) begin
                lvl_o   = lvl_l;
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pic_int_sequencer.sv
// ---------------------------------------------------------------------------
// pic_int_sequencer
// Interrupt acknowledge / in-service controller of an 8259-style PIC.
// Registers requests (IRR), holds the in-service register (ISR) and rotating
// priority base, raises INT for a request that out-ranks everything in
// service, runs the two-pulse INTA sequence returning the vector, and handles
// specific / non-specific EOI, automatic EOI and rotate-on-EOI.
//
// Parameters
//   VEC_BASE      vector base; bits [7:3] form the upper vector bits
// Ports
//   clk           in  1  rising-edge clock
//   rst           in  1  asynchronous active-high reset
//   irq_req       in  8  level requests (already synchronous to clk)
//   imr           in  8  mask, 1 = level masked
//   rotate_mode   in  1  rotate priority base on every EOI (normal or auto)
//   aeoi          in  1  automatic EOI on the second INTA
//   inta          in  1  one-cycle strobe per CPU INTA pulse
//   eoi           in  1  one-cycle EOI strobe
//   eoi_specific  in  1  1 = specific EOI, 0 = non-specific
//   eoi_level     in  3  level for a specific EOI
//   int_out       out 1  interrupt request to the CPU
//   vec_out       out 8  vector, meaningful while vec_valid is high
//   vec_valid     out 1  one-cycle vector strobe
//   irr           out 8  registered request register
//   isr           out 8  in-service register
//   prio_base     out 3  level currently holding highest priority
// ---------------------------------------------------------------------------
module pic_int_sequencer
    import pic_pkg::*;
#(
    parameter logic [7:0] VEC_BASE = 8'h08
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NLVL-1:0]  irq_req,
    input  logic [NLVL-1:0]  imr,
    input  logic             rotate_mode,
    input  logic             aeoi,
    input  logic             inta,
    input  logic             eoi,
    input  logic             eoi_specific,
    input  logic [LVL_W-1:0] eoi_level,
    output logic             int_out,
    output logic [7:0]       vec_out,
    output logic             vec_valid,
    output logic [NLVL-1:0]  irr,
    output logic [NLVL-1:0]  isr,
    output logic [LVL_W-1:0] prio_base
);

    // ---------------- state ----------------
    pic_state_e       state_q;
    logic [NLVL-1:0]  irr_q;
    logic [NLVL-1:0]  isr_q,  isr_d;
    logic [LVL_W-1:0] prio_q, prio_d;
    logic [LVL_W-1:0] sel_q;
    logic             spur_q;
    logic             int_q;
    logic [7:0]       vec_q;
    logic             vld_q;

    // ---------------- priority resolution ----------------
    logic [LVL_W-1:0] cand_lvl;
    logic             cand_found;
    logic [LVL_W-1:0] ins_lvl;
    logic             ins_found;
    logic             cand_valid;

    pic_prio_select u_cand_sel (
        .req_i   (irr_q & ~imr),
        .base_i  (prio_q),
        .lvl_o   (cand_lvl),
        .found_o (cand_found)
    );

    pic_prio_select u_isr_sel (
        .req_i   (isr_q),
        .base_i  (prio_q),
        .lvl_o   (ins_lvl),
        .found_o (ins_found)
    );

    // Fully nested: a request only interrupts if it strictly out-ranks the
    // highest level already in service (equal rank means the same level).
    assign cand_valid = cand_found &&
                        (!ins_found ||
                         (lvl_rank(cand_lvl, prio_q) < lvl_rank(ins_lvl, prio_q)));

    // ---------------- ISR / priority next state ----------------
    logic             ack_set;   // first INTA with a real winner
    logic             aeoi_clr;  // second INTA in auto-EOI mode
    logic             eoi_hit;   // EOI that actually clears a bit
    logic [LVL_W-1:0] eoi_lvl;

    assign ack_set  = (state_q == PEND) && inta && cand_valid;
    assign aeoi_clr = (state_q == ACK1) && inta && aeoi && !spur_q;

    always_comb begin
        eoi_lvl = eoi_specific ? eoi_level : ins_lvl;
        eoi_hit = eoi && (eoi_specific ? isr_q[eoi_level] : ins_found);
    end

    // Clears are applied before the acknowledge set, so a same-cycle EOI of
    // the level being acknowledged leaves that bit set.
    always_comb begin
        isr_d  = isr_q;
        prio_d = prio_q;
        if (eoi_hit) begin
            isr_d = isr_d & ~lvl_onehot(eoi_lvl);
            if (rotate_mode) prio_d = eoi_lvl + 3'd1;
        end
        if (aeoi_clr) begin
            isr_d = isr_d & ~lvl_onehot(sel_q);
            if (rotate_mode) prio_d = sel_q + 3'd1;
        end
        if (ack_set) begin
            isr_d = isr_d | lvl_onehot(cand_lvl);
        end
    end

    // ---------------- sequencer FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            irr_q   <= '0;
            isr_q   <= '0;
            prio_q  <= '0;
            sel_q   <= '0;
            spur_q  <= 1'b0;
            int_q   <= 1'b0;
            vec_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            irr_q  <= irq_req;
            isr_q  <= isr_d;
            prio_q <= prio_d;
            vld_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    // INTA outside a sequence is deliberately ignored.
                    if (cand_valid) begin
                        state_q <= PEND;
                        int_q   <= 1'b1;
                    end
                end
                PEND: begin
                    // INT stays up even if the request vanishes; the first
                    // INTA decides between a real and a spurious acknowledge.
                    if (inta) begin
                        int_q   <= 1'b0;
                        state_q <= ACK1;
                        if (cand_valid) begin
                            sel_q  <= cand_lvl;
                            spur_q <= 1'b0;
                        end else begin
                            sel_q  <= SPURIOUS_LVL;
                            spur_q <= 1'b1;
                        end
                    end
                end
                ACK1: begin
                    if (inta) begin
                        vec_q   <= {VEC_BASE[7:3], sel_q};
                        vld_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    int_q   <= 1'b0;
                end
            endcase
        end
    end

    // ---------------- outputs ----------------
    assign int_out   = int_q;
    assign vec_out   = vec_q;
    assign vec_valid = vld_q;
    assign irr       = irr_q;
    assign isr       = isr_q;
    assign prio_base = prio_q;

endmodule

// File: tb/tb_pic_int_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pic_int_sequencer
// Directed scenarios for pic_int_sequencer. Expected vectors are queued by
// the stimulus and consumed by an independent monitor on every vec_valid;
// register-state expectations are checked inline.
// ---------------------------------------------------------------------------
module tb_pic_int_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] irq_req = '0;
    logic [7:0] imr = '0;
    logic       rotate_mode = 1'b0;
    logic       aeoi = 1'b0;
    logic       inta = 1'b0;
    logic       eoi = 1'b0;
    logic       eoi_specific = 1'b0;
    logic [2:0] eoi_level = '0;
    logic       int_out;
    logic [7:0] vec_out;
    logic       vec_valid;
    logic [7:0] irr;
    logic [7:0] isr;
    logic [2:0] prio_base;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    pic_int_sequencer #(.VEC_BASE(8'h08)) dut (
        .clk          (clk),
        .rst          (rst),
        .irq_req      (irq_req),
        .imr          (imr),
        .rotate_mode  (rotate_mode),
        .aeoi         (aeoi),
        .inta         (inta),
        .eoi          (eoi),
        .eoi_specific (eoi_specific),
        .eoi_level    (eoi_level),
        .int_out      (int_out),
        .vec_out      (vec_out),
        .vec_valid    (vec_valid),
        .irr          (irr),
        .isr          (isr),
        .prio_base    (prio_base)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every vector strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (vec_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL vec_unexpected act=%02h exp=none", vec_out);
            end else begin
                mon_exp = exp_q.pop_front();
                if (vec_out !== mon_exp) begin
                    errors++;
                    $display("FAIL vec_out act=%02h exp=%02h", vec_out, mon_exp);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        irq_req = '0; imr = '0; rotate_mode = 1'b0; aeoi = 1'b0;
        inta = 1'b0; eoi = 1'b0; eoi_specific = 1'b0; eoi_level = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic pulse_inta();
        inta = 1'b1;
        tick();
        inta = 1'b0;
    endtask

    task automatic pulse_eoi(input logic spec, input logic [2:0] lvl);
        eoi = 1'b1; eoi_specific = spec; eoi_level = lvl;
        tick();
        eoi = 1'b0; eoi_specific = 1'b0;
    endtask

    // Full acknowledge: queue the vector, two INTA pulses with a gap.
    task automatic ack(input logic [7:0] exp_vec);
        exp_q.push_back(exp_vec);
        pulse_inta();
        tick();
        pulse_inta();
        tick();
    endtask

    initial begin
        // ---------------- reset state ----------------
        #2;
        chk("rst_int_out", int_out, 0);
        chk("rst_vec_valid", vec_valid, 0);
        chk("rst_vec_out", vec_out, 0);
        chk("rst_isr", isr, 0);
        chk("rst_prio", prio_base, 0);
        do_reset();
        chk("rst_irr", irr, 0);

        // ---------------- basic acknowledge ----------------
        irq_req = 8'h10;
        tick();
        chk("basic_int_1edge", int_out, 0);
        tick();
        chk("basic_int_2edge", int_out, 1);
        pulse_inta();
        chk("basic_int_fall", int_out, 0);
        chk("basic_isr_set", isr, 8'h10);
        tick();
        exp_q.push_back(8'h0C);
        pulse_inta();
        chk("basic_vec_valid", vec_valid, 1);
        tick();
        chk("basic_vec_1cyc", vec_valid, 0);
        irq_req = 8'h00;
        tick();
        pulse_eoi(1'b0, 3'd0);
        chk("basic_eoi_isr", isr, 8'h00);

        // ---------------- nesting ----------------
        do_reset();
        irq_req = 8'h10;
        tick(); tick();
        ack(8'h0C);
        chk("nest_isr4", isr, 8'h10);
        irq_req = 8'h40;
        tick(); tick(); tick();
        chk("nest_ir6_blocked", int_out, 0);
        irq_req = 8'h02;
        tick(); tick();
        chk("nest_ir1_int", int_out, 1);
        ack(8'h09);
        chk("nest_isr12", isr, 8'h12);

        // ---------------- rotation ----------------
        do_reset();
        rotate_mode = 1'b1;
        irq_req = 8'h04;
        tick(); tick();
        ack(8'h0A);
        irq_req = 8'h00;
        tick();
        pulse_eoi(1'b0, 3'd0);
        chk("rot_prio3", prio_base, 3);
        chk("rot_isr_clr", isr, 8'h00);
        irq_req = 8'h05;
        tick(); tick();
        chk("rot_int", int_out, 1);
        ack(8'h08);
        chk("rot_isr01", isr, 8'h01);

        // ---------------- spurious ----------------
        do_reset();
        irq_req = 8'h08;
        tick(); tick();
        chk("spur_int", int_out, 1);
        irq_req = 8'h00;
        tick(); tick();
        chk("spur_int_held", int_out, 1);
        ack(8'h0F);
        chk("spur_isr", isr, 8'h00);

        // ---------------- AEOI + rotate ----------------
        do_reset();
        aeoi = 1'b1; rotate_mode = 1'b1;
        irq_req = 8'h20;
        tick(); tick();
        exp_q.push_back(8'h0D);
        pulse_inta();
        chk("aeoi_isr_set", isr, 8'h20);
        irq_req = 8'h00;
        tick();
        pulse_inta();
        chk("aeoi_vec_valid", vec_valid, 1);
        chk("aeoi_isr_clr", isr, 8'h00);
        chk("aeoi_prio6", prio_base, 6);
        tick();
        chk("aeoi_vec_1cyc", vec_valid, 0);
        chk("aeoi_no_reint", int_out, 0);

        // ---------------- reset in ACK1 ----------------
        do_reset();
        irq_req = 8'h10;
        tick(); tick();
        pulse_inta();
        chk("rstack_isr_pre", isr, 8'h10);
        rst = 1'b1;
        irq_req = 8'h00;
        #1;
        chk("rstack_isr", isr, 0);
        chk("rstack_irr", irr, 0);
        chk("rstack_int", int_out, 0);
        chk("rstack_vec", vec_out, 0);
        chk("rstack_prio", prio_base, 0);
        tick();
        rst = 1'b0;
        tick();
        pulse_inta();
        chk("rstack_inta_ignored", vec_valid, 0);
        tick();
        chk("rstack_inta_ignored2", vec_valid, 0);

        // ---------------- specific EOI colliding with first INTA ----------------
        do_reset();
        irq_req = 8'h04;
        tick(); tick();
        ack(8'h0A);
        chk("coll_isr04", isr, 8'h04);
        irq_req = 8'h01;
        tick(); tick();
        chk("coll_int", int_out, 1);
        exp_q.push_back(8'h08);
        inta = 1'b1; eoi = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd2;
        tick();
        inta = 1'b0; eoi = 1'b0; eoi_specific = 1'b0;
        chk("coll_isr01", isr, 8'h01);
        tick();
        pulse_inta();
        tick();

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
